card_dealer: RTL and testbench
==============================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameters (name, default, meaning): DEAL_PERIOD, 50, cycles each dealt card stays shown; DECK_SIZE, 28, total cards per game; COUNT_INIT, 8'd100, bonus value loaded at each deal; CLEAR_CYCLES, 8, blank-table cycles after a bell; SEED, 8'hA5, LFSR reset value (never 0).
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, clock; rst, in, 1, reset, synchronous, active-low.
REQ-003 start, in, 1: begins a game; sampled only in IDLE.
REQ-004 bell_p1, bell_p2, in, 1 each: player bell levels (keypad 7 / 9 latches).
REQ-005 c1, c2, out, 2: card colours shown on player 1 / player 2 side.
REQ-006 n1, n2, out, 3: card numbers shown, 1..5; 0 = no card.
REQ-007 count, out, 8: current bonus value for a correct bell.
REQ-008 finish, out, 1: one-cycle pulse closing a bell round.
REQ-009 winner, out, 2: 01 = player 1 rang, 10 = player 2 rang, 00 = none; held from JUDGE to next deal.
REQ-010 card_valid, out, 1: one-cycle pulse on each deal.
REQ-011 game_over, out, 1: deck exhausted; held until reset.

Function
REQ-012 FSM states: IDLE, SHOW, JUDGE, CLEAR, DONE.
REQ-013 IDLE: start=1 at an edge SHALL deal the first card at that same edge (latency 1) and enter SHOW.
REQ-014 Deal: card from current LFSR value L; colour = L[1:0]; number = (L[4:2] mod 5)+1; LFSR advances one step per deal only.
REQ-015 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
REQ-016 Deals alternate sides starting with player 1; a deal overwrites only its own side; the opposite side is unchanged.
REQ-017 Each deal: card_valid=1 for one cycle, count<=COUNT_INIT, deal counter +1, show timer <= DEAL_PERIOD-1.
REQ-018 SHOW: count decrements by 1 per cycle, saturating at 1; timer decrements per cycle.
REQ-019 SHOW, timer=0, no bell: if deals<DECK_SIZE deal the next card (stay in SHOW); else enter DONE.
REQ-020 Bells are rising-edge detected against a registered previous value; only edges sampled in SHOW are accepted; edges in other states are discarded.
REQ-021 Accepted bell: enter JUDGE, freeze count, latch winner; simultaneous p1/p2 edges -> winner=01.
REQ-022 Bell edge in the same cycle as timer=0: bell takes priority; no deal.
REQ-023 JUDGE lasts exactly one cycle with finish=1, then CLEAR.
REQ-024 CLEAR: c1,c2,n1,n2,count = 0 for CLEAR_CYCLES cycles; next side resets to player 1; then deal (winner<=00) if deals<DECK_SIZE, else DONE.
REQ-025 DONE: game_over=1, all card outputs and count = 0, start ignored.
REQ-026 Deal counter width = clog2(DECK_SIZE+1); no wrap.

Reset
REQ-027 rst=0 at an edge: state IDLE, LFSR=SEED, all outputs 0, side=player 1, counters and edge registers 0; overrides any state, including JUDGE (no finish pulse emitted).

Structure
REQ-028 Shared package inner_bell_pkg: state enum, colour width (2), number width (3), winner codes, LFSR tap constant.
REQ-029 Sub-module card_lfsr (load seed, step enable, 8-bit state out); the FSM stays in card_dealer.

Verification (bench params: DEAL_PERIOD=4, DECK_SIZE=3, COUNT_INIT=10, CLEAR_CYCLES=2, SEED=A5)
REQ-030 Reset, start pulse -> next cycle c1=1, n1=2, c2=0, n2=0, count=10, card_valid=1.
REQ-031 No bells -> deals 4 cycles apart; p2 side is loaded second; count drops 10,9,8,7 and reloads at each deal; after 3 deals and 4 cycles, game_over=1 with all card outputs at 0.
REQ-032 bell_p2 rises 2 cycles after the first deal -> finish high for exactly 1 cycle, winner=10, count frozen at 8; then 2 cycles of zeros; the next deal lands on the p1 side.
REQ-033 bell_p1 and bell_p2 rise in the same cycle -> winner=01; a bell held high through CLEAR is not accepted a second time.
REQ-034 Bell edge on the timer=0 cycle -> JUDGE taken, no card_valid pulse; bell edge in IDLE or DONE -> no finish pulse.
REQ-035 rst=0 during SHOW and during JUDGE -> next cycle all outputs 0, state IDLE; restarting reproduces the REQ-030 card.

Source files
------------

// File: rtl/inner_bell_pkg.sv
// Shared types, widths and card-decoding helpers for the inner-bell card dealer.
package inner_bell_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHOW,
        ST_JUDGE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    localparam int COLOUR_W = 2;
    localparam int NUMBER_W = 3;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // x^8+x^6+x^5+x^4+1 on a left-shifting register: taps at bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [COLOUR_W-1:0] card_colour(input logic [7:0] lfsr);
        return lfsr[1:0];
    endfunction

    // Number 1..5 from a 3-bit field: (field mod 5) + 1
    function automatic logic [NUMBER_W-1:0] card_number(input logic [7:0] lfsr);
        logic [2:0] raw;
        raw = lfsr[4:2];
        return (raw >= 3'd5) ? raw - 3'd4 : raw + 3'd1;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// 8-bit Fibonacci LFSR that supplies the card stream; shifts left, feedback into bit 0.
module card_lfsr
    import inner_bell_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       i_load,
    input  logic       i_step,
    output logic [7:0] o_state
);

    logic [7:0] r_state;
    logic       w_fb;

    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= {r_state[6:0], w_fb};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/card_dealer.sv
// Card dealer for the inner-bell game: deals alternating cards, runs the bonus
// countdown, judges bell rings and blanks the table between rounds.
module card_dealer
    import inner_bell_pkg::*;
#(
    parameter int         DEAL_PERIOD  = 50,
    parameter int         DECK_SIZE    = 28,
    parameter logic [7:0] COUNT_INIT   = 8'd100,
    parameter int         CLEAR_CYCLES = 8,
    parameter logic [7:0] SEED         = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                bell_p1,
    input  logic                bell_p2,
    output logic [COLOUR_W-1:0] c1,
    output logic [COLOUR_W-1:0] c2,
    output logic [NUMBER_W-1:0] n1,
    output logic [NUMBER_W-1:0] n2,
    output logic [7:0]          count,
    output logic                finish,
    output logic [1:0]          winner,
    output logic                card_valid,
    output logic                game_over
);

    localparam int DEAL_W = $clog2(DECK_SIZE + 1);
    localparam int TMR_W  = $clog2(DEAL_PERIOD + 1);
    localparam int CLR_W  = $clog2(CLEAR_CYCLES + 1);

    localparam logic [DEAL_W-1:0] DECK_END = DEAL_W'(DECK_SIZE);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(DEAL_PERIOD - 1);
    localparam logic [CLR_W-1:0]  CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

    state_t              r_state;
    logic                r_side_p2;
    logic [DEAL_W-1:0]   r_deals;
    logic [TMR_W-1:0]    r_timer;
    logic [CLR_W-1:0]    r_clr;
    logic [1:0]          r_bell_prev;
    logic [COLOUR_W-1:0] r_c1;
    logic [COLOUR_W-1:0] r_c2;
    logic [NUMBER_W-1:0] r_n1;
    logic [NUMBER_W-1:0] r_n2;
    logic [7:0]          r_count;
    logic                r_finish;
    logic [1:0]          r_winner;
    logic                r_card_valid;
    logic                r_game_over;

    logic [7:0]          w_lfsr;
    logic [1:0]          w_edge;
    logic                w_bell;
    logic                w_more;
    logic                w_deal;
    logic [COLOUR_W-1:0] w_colour;
    logic [NUMBER_W-1:0] w_number;

    card_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk    (clk),
        .i_load (~rst),
        .i_step (w_deal),
        .o_state(w_lfsr)
    );

    assign w_colour = card_colour(w_lfsr);
    assign w_number = card_number(w_lfsr);

    // Bit 0 is player 1, bit 1 is player 2; edges only count while a card is shown
    assign w_edge = {bell_p2, bell_p1} & ~r_bell_prev;
    assign w_bell = (r_state == ST_SHOW) && (|w_edge);
    assign w_more = r_deals < DECK_END;

    always_comb begin
        w_deal = 1'b0;
        case (r_state)
            ST_IDLE:  w_deal = start;
            ST_SHOW:  w_deal = !w_bell && (r_timer == '0) && w_more;
            ST_CLEAR: w_deal = (r_clr == '0) && w_more;
            default:  w_deal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_side_p2    <= 1'b0;
            r_deals      <= '0;
            r_timer      <= '0;
            r_clr        <= '0;
            r_bell_prev  <= 2'b00;
            r_c1         <= '0;
            r_c2         <= '0;
            r_n1         <= '0;
            r_n2         <= '0;
            r_count      <= 8'd0;
            r_finish     <= 1'b0;
            r_winner     <= WIN_NONE;
            r_card_valid <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_bell_prev  <= {bell_p2, bell_p1};
            r_card_valid <= 1'b0;
            r_finish     <= 1'b0;

            if (w_deal) begin
                if (r_side_p2) begin
                    r_c2 <= w_colour;
                    r_n2 <= w_number;
                end else begin
                    r_c1 <= w_colour;
                    r_n1 <= w_number;
                end
                r_side_p2    <= ~r_side_p2;
                r_card_valid <= 1'b1;
                r_count      <= COUNT_INIT;
                r_deals      <= r_deals + 1'b1;
                r_timer      <= TMR_LOAD;
                r_winner     <= WIN_NONE;
                r_state      <= ST_SHOW;
            end else begin
                case (r_state)
                    ST_SHOW: begin
                        if (w_bell) begin
                            r_state  <= ST_JUDGE;
                            r_finish <= 1'b1;
                            r_winner <= w_edge[0] ? WIN_P1 : WIN_P2;
                        end else if (r_timer == '0) begin
                            r_state     <= ST_DONE;
                            r_game_over <= 1'b1;
                            r_c1        <= '0;
                            r_c2        <= '0;
                            r_n1        <= '0;
                            r_n2        <= '0;
                            r_count     <= 8'd0;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                            if (r_count > 8'd1) begin
                                r_count <= r_count - 8'd1;
                            end
                        end
                    end
                    ST_JUDGE: begin
                        r_state   <= ST_CLEAR;
                        r_clr     <= CLR_LOAD;
                        r_side_p2 <= 1'b0;
                        r_c1      <= '0;
                        r_c2      <= '0;
                        r_n1      <= '0;
                        r_n2      <= '0;
                        r_count   <= 8'd0;
                    end
                    ST_CLEAR: begin
                        // A non-dealing expiry here means the deck is spent
                        if (r_clr == '0) begin
                            r_state     <= ST_DONE;
                            r_game_over <= 1'b1;
                        end else begin
                            r_clr <= r_clr - 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign c1         = r_c1;
    assign c2         = r_c2;
    assign n1         = r_n1;
    assign n2         = r_n2;
    assign count      = r_count;
    assign finish     = r_finish;
    assign winner     = r_winner;
    assign card_valid = r_card_valid;
    assign game_over  = r_game_over;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: vector table plus hand-built bell/reset sequences.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       bell_p1 = 1'b0;
    logic       bell_p2 = 1'b0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [2:0] n1;
    logic [2:0] n2;
    logic [7:0] count;
    logic       finish;
    logic [1:0] winner;
    logic       card_valid;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] c1;
        logic [2:0] n1;
        logic [1:0] c2;
        logic [2:0] n2;
        logic [7:0] cnt;
        logic       fin;
        logic [1:0] win;
        logic       cv;
        logic       go;
    } out_t;

    typedef struct packed {
        logic rst;
        logic start;
        logic b1;
        logic b2;
        out_t exp;
    } vec_t;

    out_t  exp_q[$];
    string name_q[$];

    card_dealer #(
        .DEAL_PERIOD (4),
        .DECK_SIZE   (3),
        .COUNT_INIT  (8'd10),
        .CLEAR_CYCLES(2),
        .SEED        (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bell_p1   (bell_p1),
        .bell_p2   (bell_p2),
        .c1        (c1),
        .c2        (c2),
        .n1        (n1),
        .n2        (n2),
        .count     (count),
        .finish    (finish),
        .winner    (winner),
        .card_valid(card_valid),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input int a_c1, input int a_n1, input int a_c2, input int a_n2,
                                input int a_cnt, input int a_fin, input int a_win,
                                input int a_cv, input int a_go);
        out_t o;
        o.c1  = a_c1[1:0];
        o.n1  = a_n1[2:0];
        o.c2  = a_c2[1:0];
        o.n2  = a_n2[2:0];
        o.cnt = a_cnt[7:0];
        o.fin = a_fin[0];
        o.win = a_win[1:0];
        o.cv  = a_cv[0];
        o.go  = a_go[0];
        return o;
    endfunction

    function automatic vec_t vec(input logic r, input logic s, input logic b1, input logic b2,
                                 input out_t e);
        vec_t v;
        v.rst   = r;
        v.start = s;
        v.b1    = b1;
        v.b2    = b2;
        v.exp   = e;
        return v;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("c1=%0d n1=%0d c2=%0d n2=%0d count=%0d finish=%0d winner=%b valid=%0d over=%0d",
                         o.c1, o.n1, o.c2, o.n2, o.cnt, o.fin, o.win, o.cv, o.go);
    endfunction

    // Drive one cycle of inputs, queue its expectation, then compare after the edge
    task automatic apply(input string nm, input vec_t v);
        out_t got;
        out_t want;
        string wname;
        rst     = v.rst;
        start   = v.start;
        bell_p1 = v.b1;
        bell_p2 = v.b2;
        exp_q.push_back(v.exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        got   = '{c1: c1, n1: n1, c2: c2, n2: n2, cnt: count, fin: finish, win: winner,
                  cv: card_valid, go: game_over};
        want  = exp_q.pop_front();
        wname = name_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got [%s] required [%s]", wname, fmt(got), fmt(want));
        end
    endtask

    initial begin
        vec_t tbl [17];
        out_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Full game without bells: cards A5 -> (1,2), 4A -> (2,3), 95 -> (1,1)
        tbl[0]  = vec(0, 0, 0, 0, z);
        tbl[1]  = vec(1, 0, 1, 0, z);
        tbl[2]  = vec(1, 1, 0, 0, mk(1, 2, 0, 0, 10, 0, 0, 1, 0));
        tbl[3]  = vec(1, 0, 0, 0, mk(1, 2, 0, 0, 9, 0, 0, 0, 0));
        tbl[4]  = vec(1, 0, 0, 0, mk(1, 2, 0, 0, 8, 0, 0, 0, 0));
        tbl[5]  = vec(1, 0, 0, 0, mk(1, 2, 0, 0, 7, 0, 0, 0, 0));
        tbl[6]  = vec(1, 0, 0, 0, mk(1, 2, 2, 3, 10, 0, 0, 1, 0));
        tbl[7]  = vec(1, 0, 0, 0, mk(1, 2, 2, 3, 9, 0, 0, 0, 0));
        tbl[8]  = vec(1, 0, 0, 0, mk(1, 2, 2, 3, 8, 0, 0, 0, 0));
        tbl[9]  = vec(1, 0, 0, 0, mk(1, 2, 2, 3, 7, 0, 0, 0, 0));
        tbl[10] = vec(1, 0, 0, 0, mk(1, 1, 2, 3, 10, 0, 0, 1, 0));
        tbl[11] = vec(1, 0, 0, 0, mk(1, 1, 2, 3, 9, 0, 0, 0, 0));
        tbl[12] = vec(1, 0, 0, 0, mk(1, 1, 2, 3, 8, 0, 0, 0, 0));
        tbl[13] = vec(1, 0, 0, 0, mk(1, 1, 2, 3, 7, 0, 0, 0, 0));
        tbl[14] = vec(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl[15] = vec(1, 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl[16] = vec(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < 17; i++) begin
            apply($sformatf("game_row%0d", i), tbl[i]);
        end

        // Player 2 rings while count reads 8; next deal restarts on player 1 side
        apply("p2_reset",   vec(0, 0, 0, 0, z));
        apply("p2_deal",    vec(1, 1, 0, 0, mk(1, 2, 0, 0, 10, 0, 0, 1, 0)));
        apply("p2_cnt9",    vec(1, 0, 0, 0, mk(1, 2, 0, 0, 9, 0, 0, 0, 0)));
        apply("p2_cnt8",    vec(1, 0, 0, 0, mk(1, 2, 0, 0, 8, 0, 0, 0, 0)));
        apply("p2_judge",   vec(1, 0, 0, 1, mk(1, 2, 0, 0, 8, 1, 2, 0, 0)));
        apply("p2_clear1",  vec(1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 2, 0, 0)));
        apply("p2_clear2",  vec(1, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 2, 0, 0)));
        apply("p2_redeal",  vec(1, 0, 0, 1, mk(2, 3, 0, 0, 10, 0, 0, 1, 0)));
        apply("p2_show",    vec(1, 0, 0, 0, mk(2, 3, 0, 0, 9, 0, 0, 0, 0)));

        // Both bells on the timer-expiry cycle; bells then held through CLEAR
        apply("both_reset", vec(0, 0, 0, 0, z));
        apply("both_deal",  vec(1, 1, 0, 0, mk(1, 2, 0, 0, 10, 0, 0, 1, 0)));
        apply("both_cnt9",  vec(1, 0, 0, 0, mk(1, 2, 0, 0, 9, 0, 0, 0, 0)));
        apply("both_cnt8",  vec(1, 0, 0, 0, mk(1, 2, 0, 0, 8, 0, 0, 0, 0)));
        apply("both_cnt7",  vec(1, 0, 0, 0, mk(1, 2, 0, 0, 7, 0, 0, 0, 0)));
        apply("both_judge", vec(1, 0, 1, 1, mk(1, 2, 0, 0, 7, 1, 1, 0, 0)));
        apply("both_clr1",  vec(1, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0)));
        apply("both_clr2",  vec(1, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0)));
        apply("both_redeal", vec(1, 0, 1, 1, mk(2, 3, 0, 0, 10, 0, 0, 1, 0)));
        apply("both_held",  vec(1, 0, 1, 1, mk(2, 3, 0, 0, 9, 0, 0, 0, 0)));
        apply("show_reset", vec(0, 0, 0, 0, z));
        apply("show_restart", vec(1, 1, 0, 0, mk(1, 2, 0, 0, 10, 0, 0, 1, 0)));

        // Reset landing on the JUDGE cycle suppresses the round entirely
        apply("jdg_enter",  vec(1, 0, 1, 0, mk(1, 2, 0, 0, 10, 1, 1, 0, 0)));
        apply("jdg_reset",  vec(0, 0, 1, 0, z));
        apply("jdg_idle",   vec(1, 0, 0, 0, z));
        apply("jdg_restart", vec(1, 1, 0, 0, mk(1, 2, 0, 0, 10, 0, 0, 1, 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog reached before end of stimulus");
        $fatal(1);
    end

endmodule
